oam_manager: RTL and testbench

OAM_MANAGER -- requirements
Module: oam_manager

---
 rtl/oam_pkg.sv | 60 ++++++
 rtl/oam_manager_if.sv | 12 +
 rtl/oam_table_dp.sv | 32 +++
 rtl/oam_manager.sv | 109 ++++++++++
 tb/tb_oam_manager.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/oam_pkg.sv
// Shared OAM definitions: entry layout, screen/tile geometry and write-side sanitising.
// Build option: OAM_POS_CLAMP_EN clamps sprite positions on write.
package oam_pkg;

  localparam int unsigned OAM_DEPTH = 8;
  localparam int unsigned OAM_WIDTH = 32;
  localparam int unsigned IDX_W     = $clog2(OAM_DEPTH);

  localparam int unsigned TILE_SIZE = 32;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned CLAMP_X   = SCREEN_W - TILE_SIZE;
  localparam int unsigned CLAMP_Y   = SCREEN_H - TILE_SIZE;

  // Field positions (lsb) and widths inside a packed entry
  localparam int unsigned RSVD_BIT       = 31;
  localparam int unsigned TYPE_LSB       = 29;
  localparam int unsigned TYPE_W         = 2;
  localparam int unsigned ENABLE_BIT     = 28;
  localparam int unsigned POS_X_LSB      = 18;
  localparam int unsigned POS_X_W        = 10;
  localparam int unsigned POS_Y_LSB      = 8;
  localparam int unsigned POS_Y_W        = 10;
  localparam int unsigned DIR_LSB        = 6;
  localparam int unsigned DIR_W          = 2;
  localparam int unsigned SPRITE_ROW_LSB = 3;
  localparam int unsigned SPRITE_ROW_W   = 3;
  localparam int unsigned SPRITE_COL_LSB = 0;
  localparam int unsigned SPRITE_COL_W   = 3;

  typedef struct packed {
    logic                    rsvd;
    logic [TYPE_W-1:0]       obj_type;
    logic                    enable;
    logic [POS_X_W-1:0]      pos_x;
    logic [POS_Y_W-1:0]      pos_y;
    logic [DIR_W-1:0]        dir;
    logic [SPRITE_ROW_W-1:0] sprite_row;
    logic [SPRITE_COL_W-1:0] sprite_col;
  } oam_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } oam_state_e;

  // Reserved bit is always stored as zero; positions optionally kept on-screen.
  function automatic oam_entry_t sanitize_entry(input logic [OAM_WIDTH-1:0] raw);
    oam_entry_t e;
    e      = oam_entry_t'(raw);
    e.rsvd = 1'b0;
`ifdef OAM_POS_CLAMP_EN
    if (e.pos_x > POS_X_W'(CLAMP_X)) e.pos_x = POS_X_W'(CLAMP_X);
    if (e.pos_y > POS_Y_W'(CLAMP_Y)) e.pos_y = POS_Y_W'(CLAMP_Y);
`else
`endif
    return e;
  endfunction

endpackage

// File: rtl/oam_manager_if.sv
// Game-logic write channel into the OAM shadow table (valid/ready handshake).
interface oam_manager_if;
  import oam_pkg::*;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [IDX_W-1:0]     wr_idx;
  logic [OAM_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_idx, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_idx, input wr_data, output wr_ready);
endinterface

// File: rtl/oam_table_dp.sv
// Register-array table: one write port, one registered read port, cleared on reset.
// Read-during-write to the same index returns the old contents.
module oam_table_dp #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/oam_manager.sv
// Double-buffered OAM: game logic fills a shadow table, which is copied into the
// renderer-facing active table one entry per cycle at the first vblank after a commit.
module oam_manager
  import oam_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  oam_manager_if.slave         wr,
  input  logic                 commit_req,
  input  logic                 frame_start,
  input  logic [IDX_W-1:0]     oam_addr,
  output logic [OAM_WIDTH-1:0] oam_data,
  output logic                 busy,
  output logic                 committed
);

  oam_state_e           state_q;
  logic                 pending_q;
  logic [IDX_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 committed_q;
  logic                 wr_ready_q;
  logic                 fwd_q;
  logic [OAM_WIDTH-1:0] fwd_data_q;

  logic                 wr_fire_c;
  oam_entry_t           wr_entry_c;
  logic [IDX_W-1:0]     shadow_raddr_c;
  logic [OAM_WIDTH-1:0] shadow_rdata;
  logic [OAM_WIDTH-1:0] copy_data_c;
  logic                 copy_we_c;

  assign wr_fire_c  = wr.wr_valid && wr_ready_q;
  assign wr_entry_c = sanitize_entry(wr.wr_data);

  // Shadow reads run one entry ahead so each COPY cycle has its source word ready.
  assign shadow_raddr_c = (state_q == ST_COPY) ? IDX_W'(cnt_q + 1'b1) : '0;
  assign copy_we_c      = (state_q == ST_COPY);
  // A write landing on the pre-fetched index in the same edge wins over the stale read.
  assign copy_data_c    = fwd_q ? fwd_data_q : shadow_rdata;

  oam_table_dp #(.DEPTH(OAM_DEPTH), .WIDTH(OAM_WIDTH)) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_fire_c),
    .waddr_i (wr.wr_idx),
    .wdata_i (wr_entry_c),
    .raddr_i (shadow_raddr_c),
    .rdata_o (shadow_rdata)
  );

  oam_table_dp #(.DEPTH(OAM_DEPTH), .WIDTH(OAM_WIDTH)) u_active (
    .clk     (clk),
    .rst     (rst),
    .we_i    (copy_we_c),
    .waddr_i (cnt_q),
    .wdata_i (copy_data_c),
    .raddr_i (oam_addr),
    .rdata_o (oam_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      committed_q <= 1'b0;
      wr_ready_q  <= 1'b1;
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      committed_q <= 1'b0;
      fwd_q       <= wr_fire_c && (wr.wr_idx == shadow_raddr_c);
      fwd_data_q  <= wr_entry_c;
      case (state_q)
        ST_IDLE: begin
          if (frame_start && pending_q) begin
            state_q    <= ST_COPY;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
          end else if (commit_req) begin
            pending_q <= 1'b1;
          end
        end
        ST_COPY: begin
          if (commit_req) pending_q <= 1'b1;
          if (cnt_q == IDX_W'(OAM_DEPTH - 1)) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            wr_ready_q  <= 1'b1;
            committed_q <= 1'b1;
          end else begin
            cnt_q <= IDX_W'(cnt_q + 1'b1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr.wr_ready = wr_ready_q;
  assign busy        = busy_q;
  assign committed   = committed_q;

endmodule

// File: tb/tb_oam_manager.sv
// Scoreboarded bench for oam_manager: directed scenarios then random traffic,
// checked against a table/queue model of the double-buffered OAM.
module tb_oam_manager;
  import oam_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit_req = 1'b0;
  logic        frame_start = 1'b0;
  logic [2:0]  oam_addr = 3'd0;
  logic [31:0] oam_data;
  logic        busy;
  logic        committed;

  oam_manager_if wr ();

  oam_manager dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .commit_req  (commit_req),
    .frame_start (frame_start),
    .oam_addr    (oam_addr),
    .oam_data    (oam_data),
    .busy        (busy),
    .committed   (committed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        busy;
    logic        committed;
    logic        ready;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  // Reference model: two plain arrays, a pending flag, and a queue of indices still to copy.
  logic [31:0] m_shadow [8];
  logic [31:0] m_active [8];
  bit          m_pend;
  int          m_copy_q[$];

  function automatic logic [31:0] spec_store(input logic [31:0] raw);
    logic [31:0] v;
    int          px;
    int          py;
    v     = raw;
    v[31] = 1'b0;
    px    = int'(v[27:18]);
    py    = int'(v[17:8]);
`ifdef OAM_POS_CLAMP_EN
    if (px > 608) px = 608;
    if (py > 448) py = 448;
`endif
    v[27:18] = 10'(px);
    v[17:8]  = 10'(py);
    return v;
  endfunction

  task automatic step(input bit r, input bit wv, input logic [2:0] idx, input logic [31:0] d,
                      input bit cr, input bit fs, input logic [2:0] addr);
    exp_t e;
    bit   was_busy;
    int   k;
    @(negedge clk);
    rst         = r;
    wr.wr_valid = wv;
    wr.wr_idx   = idx;
    wr.wr_data  = d;
    commit_req  = cr;
    frame_start = fs;
    oam_addr    = addr;
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
      m_pend = 1'b0;
      m_copy_q.delete();
      e.data = '0; e.busy = 1'b0; e.committed = 1'b0; e.ready = 1'b1;
    end else begin
      was_busy    = (m_copy_q.size() != 0);
      e.data      = m_active[addr];
      e.committed = 1'b0;
      if (!was_busy && wv) m_shadow[idx] = spec_store(d);
      if (was_busy) begin
        k = m_copy_q.pop_front();
        m_active[k] = m_shadow[k];
        if (m_copy_q.size() == 0) e.committed = 1'b1;
      end
      if (!was_busy && fs && m_pend) begin
        m_pend = 1'b0;
        for (int i = 0; i < 8; i++) m_copy_q.push_back(i);
      end else if (cr) begin
        m_pend = 1'b1;
      end
      e.busy  = (m_copy_q.size() != 0);
      e.ready = !e.busy;
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [2:0] addr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, addr);
  endtask

  task automatic wr_one(input logic [2:0] idx, input logic [31:0] d);
    step(1'b0, 1'b1, idx, d, 1'b0, 1'b0, idx);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("oam_data",  oam_data,           e.data);
        check("busy",      32'(busy),          32'(e.busy));
        check("committed", 32'(committed),     32'(e.committed));
        check("wr_ready",  32'(wr.wr_ready),   32'(e.ready));
      end
    end
  end

  initial begin
    logic [31:0] d;
    wr.wr_valid = 1'b0;
    wr.wr_idx   = 3'd0;
    wr.wr_data  = 32'd0;

    step(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd3);
    idle(2, 3'd3);

    // Full commit: reserved bit dropped, 8-cycle copy, committed pulse
    wr_one(3'd3, 32'h9FFF_FFFF);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'd3);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 3'd3);
    idle(11, 3'd3);

    // vblank without commit does nothing
    wr_one(3'd0, 32'h1234_5678);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 3'd0);
    idle(10, 3'd0);

    // commit and vblank together only arm; next vblank copies
    wr_one(3'd1, 32'h0ABC_DEF1);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b1, 3'd1);
    idle(3, 3'd1);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 3'd1);
    idle(11, 3'd1);

    // Write held through a copy lands on the first idle cycle; frame_start ignored mid-copy
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'd5);
    step(1'b0, 1'b1, 3'd0, 32'h1111_0000, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 3'd5, 32'hC5C5_5C5C, 1'b0, (i == 3), 3'd5);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'd5);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 3'd5);
    idle(11, 3'd5);

    // Position at 700/470 (clamped or stored as-is depending on build)
    d = (32'd700 << 18) | (32'd470 << 8) | (32'd1 << 28);
    wr_one(3'd2, d);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'd2);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 3'd2);
    idle(11, 3'd2);

    // Reset in the middle of a copy wipes both tables
    wr_one(3'd4, 32'h7777_7777);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'd4);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 3'd4);
    idle(4, 3'd4);
    step(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd4);
    step(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd4);
    for (int i = 0; i < 9; i++) idle(1, 3'(i));
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 3'd0);
    idle(9, 3'd0);
    for (int i = 0; i < 9; i++) idle(1, 3'(i));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 1) == 1),
           3'($urandom),
           $urandom,
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           3'($urandom));
    end
    idle(12, 3'd0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
